// File: rtl/intc_pkg.sv
// ----------------------------------------------------------------------------
// intc_pkg
// Shared definitions for the interrupt controller.
//   - Register offsets as seen on bus addr[3:2]
//   - Arbiter FSM state encoding
//   - Bit positions of the fields in the CTRL register
// ----------------------------------------------------------------------------
package intc_pkg;

    // Register offsets (bus addr[3:2])
    localparam logic [1:0] INTC_PEND  = 2'd0;
    localparam logic [1:0] INTC_MASK  = 2'd1;
    localparam logic [1:0] INTC_CLAIM = 2'd2;
    localparam logic [1:0] INTC_CTRL  = 2'd3;

    // CTRL field positions
    localparam int CTRL_GIE_BIT   = 0;
    localparam int CTRL_EDGE_BASE = 8;

    // CLAIM valid flag position
    localparam int CLAIM_VALID_BIT = 31;

    // Arbiter state encoding
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } intc_state_e;

endpackage

// File: rtl/intc_prio_pick.sv
// ----------------------------------------------------------------------------
// intc_prio_pick
// Combinational find-first-set over NSRC request bits. The scan begins at
// 'start' and wraps from NSRC-1 back to 0. Tie 'start' to zero for plain
// lowest-index-first priority.
// Ports:
//   req    in  NSRC  request vector
//   start  in  IDW   index at which the scan begins (must be < NSRC)
//   id     out IDW   index of the first set bit found
//   found  out 1     at least one request bit is set
// ----------------------------------------------------------------------------
module intc_prio_pick #(
    parameter int NSRC = 6,
    parameter int IDW  = 3
) (
    input  logic [NSRC-1:0] req,
    input  logic [IDW-1:0]  start,
    output logic [IDW-1:0]  id,
    output logic            found
);

    // Rotating scan: the first hit after 'start' wins. The sum carries one
    // extra bit so start+i never overflows before the wrap is applied.
    always_comb begin
        logic [IDW:0]   sum_v;
        logic [IDW-1:0] idx_v;
        logic           hit_v;
        id    = {IDW{1'b0}};
        found = 1'b0;
        sum_v = {(IDW+1){1'b0}};
        idx_v = {IDW{1'b0}};
        hit_v = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            sum_v = {1'b0, start} + (IDW+1)'(i);
            sum_v = (sum_v >= (IDW+1)'(NSRC)) ? (sum_v - (IDW+1)'(NSRC)) : sum_v;
            idx_v = sum_v[IDW-1:0];
            hit_v = req[idx_v] & ~found;
            id    = hit_v ? idx_v : id;
            found = found | req[idx_v];
        end
    end

endmodule

// File: rtl/intc_ctrl.sv
// ----------------------------------------------------------------------------
// intc_ctrl
// Interrupt controller / arbiter between device IRQ lines and the CPU.
// Latches and masks requests, selects one winner and holds a single IRQ to
// the CPU until software writes an end-of-interrupt (EOI) carrying the id.
//
// Optional build macro:
//   INTC_ROUND_ROBIN_EN  - winner search starts after the last serviced id
//                          (round robin); otherwise lowest index wins.
//
// Ports:
//   clk         in   1     system clock
//   rst         in   1     asynchronous, active-low reset
//   addr        in   2     register select (bus addr[3:2])
//   we          in   1     write strobe, one cycle per store
//   DEV_WD      in   32    write data
//   DEVIntc_RD  out  32    read data, combinational from addr
//   irq_in      in   NSRC  device requests, synchronous to clk
//   IRQ         out  1     registered interrupt request to the CPU
// ----------------------------------------------------------------------------
module intc_ctrl
    import intc_pkg::*;
#(
    parameter int NSRC = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      addr,
    input  logic            we,
    input  logic [31:0]     DEV_WD,
    output logic [31:0]     DEVIntc_RD,
    input  logic [NSRC-1:0] irq_in,
    output logic            IRQ
);

    localparam int IDW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam logic [NSRC-1:0] SRC_ONE = NSRC'(1);

    logic [NSRC-1:0] pend_r;
    logic [NSRC-1:0] mask_r;
    logic [NSRC-1:0] edge_r;
    logic [NSRC-1:0] irq_q_r;
    logic            gie_r;
    logic [IDW-1:0]  cur_id_r;
    intc_state_e     state_r;
    logic            irq_r;

    logic            wr_pend_s;
    logic            wr_mask_s;
    logic            wr_claim_s;
    logic            wr_ctrl_s;
    logic            eoi_ok_s;
    logic [NSRC-1:0] set_s;
    logic [NSRC-1:0] clr_s;
    logic [NSRC-1:0] eoi_bit_s;
    logic [NSRC-1:0] eligible_s;
    logic [IDW-1:0]  start_s;
    logic [IDW-1:0]  win_id_s;
    logic            win_found_s;
    logic [31:0]     rd_s;
    logic            unused_wd_s;

    assign wr_pend_s  = we && (addr == INTC_PEND);
    assign wr_mask_s  = we && (addr == INTC_MASK);
    assign wr_claim_s = we && (addr == INTC_CLAIM);
    assign wr_ctrl_s  = we && (addr == INTC_CTRL);

    // Edge sources set on a rising edge, level sources while the line is high.
    assign set_s = irq_in & (~edge_r | ~irq_q_r);

    // Only an EOI naming the id currently being serviced is honoured.
    assign eoi_ok_s  = wr_claim_s && (state_r == ACTIVE) && (DEV_WD[IDW-1:0] == cur_id_r);
    assign eoi_bit_s = eoi_ok_s ? (SRC_ONE << cur_id_r) : {NSRC{1'b0}};
    assign clr_s     = (wr_pend_s ? DEV_WD[NSRC-1:0] : {NSRC{1'b0}}) | eoi_bit_s;

    // A high level line is eligible in the cycle it is seen, one cycle ahead
    // of its pend bit; edge sources only become eligible once latched.
    assign eligible_s = (pend_r | (irq_in & ~edge_r)) & mask_r;

    // Bus write bits outside the implemented fields are intentionally dropped.
    assign unused_wd_s = &{1'b0, DEV_WD};

    intc_prio_pick #(
        .NSRC (NSRC),
        .IDW  (IDW)
    ) u_pick (
        .req   (eligible_s),
        .start (start_s),
        .id    (win_id_s),
        .found (win_found_s)
    );

`ifdef INTC_ROUND_ROBIN_EN
    logic [IDW-1:0] rr_ptr_r;

    // Move the search origin just past the source that was serviced.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_r <= {IDW{1'b0}};
        end else if (eoi_ok_s) begin
            rr_ptr_r <= (cur_id_r == IDW'(NSRC - 1)) ? {IDW{1'b0}} : (cur_id_r + IDW'(1));
        end
    end

    assign start_s = rr_ptr_r;
`else
    assign start_s = {IDW{1'b0}};
`endif

    // Register file: pending latch (set beats clear), mask, control, input delay.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_r  <= {NSRC{1'b0}};
            mask_r  <= {NSRC{1'b0}};
            edge_r  <= {NSRC{1'b0}};
            gie_r   <= 1'b0;
            irq_q_r <= {NSRC{1'b0}};
        end else begin
            irq_q_r <= irq_in;
            pend_r  <= (pend_r & ~clr_s) | set_s;
            if (wr_mask_s) begin
                mask_r <= DEV_WD[NSRC-1:0];
            end
            if (wr_ctrl_s) begin
                gie_r  <= DEV_WD[CTRL_GIE_BIT];
                edge_r <= DEV_WD[CTRL_EDGE_BASE +: NSRC];
            end
        end
    end

    // Arbiter FSM: claim a winner, hold until EOI or GIE off, then one idle gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            cur_id_r <= {IDW{1'b0}};
            irq_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (gie_r && win_found_s) begin
                        state_r  <= ACTIVE;
                        cur_id_r <= win_id_s;
                        irq_r    <= 1'b1;
                    end else begin
                        irq_r    <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (wr_ctrl_s && !DEV_WD[CTRL_GIE_BIT]) begin
                        state_r <= IDLE;
                        irq_r   <= 1'b0;
                    end else if (eoi_ok_s) begin
                        state_r <= GAP;
                        irq_r   <= 1'b0;
                    end else begin
                        irq_r   <= 1'b1;
                    end
                end
                GAP: begin
                    // Guarantees the CPU sees IRQ low before any re-assertion.
                    state_r <= IDLE;
                    irq_r   <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    irq_r   <= 1'b0;
                end
            endcase
        end
    end

    assign IRQ = irq_r;

    // Read mux; unimplemented bits read as zero.
    always_comb begin
        rd_s = 32'd0;
        case (addr)
            INTC_PEND: begin
                rd_s[NSRC-1:0] = pend_r;
            end
            INTC_MASK: begin
                rd_s[NSRC-1:0] = mask_r;
            end
            INTC_CLAIM: begin
                rd_s[CLAIM_VALID_BIT] = (state_r == ACTIVE);
                rd_s[IDW-1:0]         = cur_id_r;
            end
            INTC_CTRL: begin
                rd_s[CTRL_GIE_BIT]            = gie_r;
                rd_s[CTRL_EDGE_BASE +: NSRC]  = edge_r;
            end
            default: begin
                rd_s = 32'd0;
            end
        endcase
    end

    assign DEVIntc_RD = rd_s;

endmodule

// File: tb/tb_intc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_intc_ctrl
// Self-checking bench for intc_ctrl: table of per-cycle vectors plus
// hand-written sequences for reset and arbitration order. Expected values are
// queued when stimulus is driven and popped when the DUT output is sampled.
// ----------------------------------------------------------------------------
module tb_intc_ctrl;
    import intc_pkg::*;

    localparam int NSRC = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      addr;
    logic            we;
    logic [31:0]     DEV_WD;
    logic [31:0]     DEVIntc_RD;
    logic [NSRC-1:0] irq_in;
    logic            IRQ;

    always #5 clk = ~clk;

    intc_ctrl #(.NSRC(NSRC)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .we         (we),
        .DEV_WD     (DEV_WD),
        .DEVIntc_RD (DEVIntc_RD),
        .irq_in     (irq_in),
        .IRQ        (IRQ)
    );

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    typedef struct {
        logic            we;
        logic [1:0]      addr;
        logic [31:0]     wd;
        logic [NSRC-1:0] irq;
        logic [31:0]     rd;
        logic            irq_exp;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_val(input string name, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic compare(input logic [31:0] act);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %h with nothing expected", act);
        end else begin
            e = sb_q.pop_front();
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    endtask

    task automatic add_v(input logic w, input logic [1:0] a, input logic [31:0] d,
                         input logic [NSRC-1:0] i, input logic [31:0] r, input logic q);
        vec_t v;
        v.we = w; v.addr = a; v.wd = d; v.irq = i; v.rd = r; v.irq_exp = q;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rr_exp [4];
        logic [2:0]  id_v;

        rst = 1'b0; we = 1'b0; addr = INTC_PEND; DEV_WD = 32'd0; irq_in = 6'h3F;

        // Reset held with all requests high
        step(); step();
        expect_val("reset_irq", 32'd0);
        compare({31'd0, IRQ});
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            #1;
            expect_val($sformatf("reset_reg%0d", a), 32'd0);
            compare(DEVIntc_RD);
        end
        rst = 1'b1;

        // Vector table: we, addr, wd, irq_in, expected read this cycle, expected IRQ after edge
        add_v(1'b0, INTC_PEND,  32'h0,    6'h3F, 32'h0,         1'b0); // 0
        add_v(1'b0, INTC_PEND,  32'h0,    6'h3F, 32'h3F,        1'b0); // 1 level pend, GIE=0
        add_v(1'b1, INTC_MASK,  32'h3F,   6'h00, 32'h0,         1'b0); // 2
        add_v(1'b1, INTC_PEND,  32'h3F,   6'h00, 32'h3F,        1'b0); // 3 W1C all
        add_v(1'b0, INTC_PEND,  32'h0,    6'h00, 32'h0,         1'b0); // 4
        add_v(1'b1, INTC_CTRL,  32'h1,    6'h00, 32'h0,         1'b0); // 5 GIE=1
        add_v(1'b0, INTC_CLAIM, 32'h0,    6'h04, 32'h0,         1'b1); // 6 level src2 -> IRQ N+1
        add_v(1'b0, INTC_CLAIM, 32'h0,    6'h00, 32'h8000_0002, 1'b1); // 7
        add_v(1'b1, INTC_CLAIM, 32'h2,    6'h00, 32'h8000_0002, 1'b0); // 8 EOI 2
        add_v(1'b0, INTC_PEND,  32'h0,    6'h00, 32'h0,         1'b0); // 9 GAP
        add_v(1'b0, INTC_PEND,  32'h0,    6'h00, 32'h0,         1'b0); // 10
        add_v(1'b1, INTC_CTRL,  32'h3F01, 6'h00, 32'h1,         1'b0); // 11 edge mode
        add_v(1'b0, INTC_PEND,  32'h0,    6'h10, 32'h0,         1'b0); // 12 pulse src4
        add_v(1'b0, INTC_PEND,  32'h0,    6'h00, 32'h10,        1'b1); // 13 IRQ at N+2
        add_v(1'b1, INTC_PEND,  32'h10,   6'h00, 32'h10,        1'b1); // 14 W1C while active
        add_v(1'b0, INTC_CLAIM, 32'h0,    6'h00, 32'h8000_0004, 1'b1); // 15
        add_v(1'b0, INTC_PEND,  32'h0,    6'h00, 32'h0,         1'b1); // 16
        add_v(1'b1, INTC_CLAIM, 32'h4,    6'h00, 32'h8000_0004, 1'b0); // 17 EOI 4
        add_v(1'b0, INTC_PEND,  32'h0,    6'h00, 32'h0,         1'b0); // 18
        add_v(1'b0, INTC_PEND,  32'h0,    6'h0A, 32'h0,         1'b0); // 19 pulse src1+src3
        add_v(1'b0, INTC_PEND,  32'h0,    6'h00, 32'h0A,        1'b1); // 20
        add_v(1'b0, INTC_CLAIM, 32'h0,    6'h00, 32'h8000_0001, 1'b1); // 21 fixed priority
        add_v(1'b1, INTC_CLAIM, 32'h1,    6'h00, 32'h8000_0001, 1'b0); // 22 EOI 1
        add_v(1'b0, INTC_CLAIM, 32'h0,    6'h00, 32'h1,         1'b0); // 23 GAP, not valid
        add_v(1'b0, INTC_PEND,  32'h0,    6'h00, 32'h08,        1'b1); // 24 re-assert N+3
        add_v(1'b0, INTC_CLAIM, 32'h0,    6'h00, 32'h8000_0003, 1'b1); // 25
        add_v(1'b1, INTC_CLAIM, 32'h5,    6'h00, 32'h8000_0003, 1'b1); // 26 bad EOI ignored
        add_v(1'b0, INTC_CLAIM, 32'h0,    6'h00, 32'h8000_0003, 1'b1); // 27
        add_v(1'b1, INTC_CLAIM, 32'h3,    6'h00, 32'h8000_0003, 1'b0); // 28 EOI 3
        add_v(1'b0, INTC_PEND,  32'h0,    6'h00, 32'h0,         1'b0); // 29
        add_v(1'b1, INTC_PEND,  32'h1,    6'h01, 32'h0,         1'b0); // 30 set beats W1C
        add_v(1'b0, INTC_PEND,  32'h0,    6'h00, 32'h1,         1'b1); // 31
        add_v(1'b0, INTC_CLAIM, 32'h0,    6'h00, 32'h8000_0000, 1'b1); // 32
        add_v(1'b1, INTC_CTRL,  32'h3F00, 6'h00, 32'h3F01,      1'b0); // 33 GIE off in ACTIVE
        add_v(1'b0, INTC_PEND,  32'h0,    6'h00, 32'h1,         1'b0); // 34 pend untouched
        add_v(1'b1, INTC_CTRL,  32'h3F01, 6'h00, 32'h3F00,      1'b0); // 35 GIE on
        add_v(1'b0, INTC_PEND,  32'h0,    6'h00, 32'h1,         1'b1); // 36
        add_v(1'b0, INTC_CLAIM, 32'h0,    6'h00, 32'h8000_0000, 1'b1); // 37

        foreach (vecs[i]) begin
            we = vecs[i].we; addr = vecs[i].addr; DEV_WD = vecs[i].wd; irq_in = vecs[i].irq;
            expect_val($sformatf("vec%0d_rd", i), vecs[i].rd);
            expect_val($sformatf("vec%0d_irq", i), {31'd0, vecs[i].irq_exp});
            #4;
            compare(DEVIntc_RD);
            step();
            we = 1'b0;
            compare({31'd0, IRQ});
        end

        // Asynchronous reset while ACTIVE
        #2;
        rst = 1'b0;
        addr = INTC_PEND;
        #1;
        expect_val("async_rst_irq", 32'd0);
        compare({31'd0, IRQ});
        expect_val("async_rst_pend", 32'd0);
        compare(DEVIntc_RD);
        addr = INTC_CLAIM;
        #1;
        expect_val("async_rst_claim", 32'd0);
        compare(DEVIntc_RD);
        step();
        rst = 1'b1;
        irq_in = 6'h00;
        step();

        // Arbitration order with sources 0 and 1 held high (level)
`ifdef INTC_ROUND_ROBIN_EN
        rr_exp = '{32'd0, 32'd1, 32'd0, 32'd1};
`else
        rr_exp = '{32'd0, 32'd0, 32'd0, 32'd0};
`endif
        irq_in = 6'h03;
        we = 1'b1; addr = INTC_MASK; DEV_WD = 32'h3;
        step();
        addr = INTC_CTRL; DEV_WD = 32'h1;
        step();
        we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            expect_val($sformatf("order%0d_irq", k), 32'd1);
            expect_val($sformatf("order%0d_claim", k), 32'h8000_0000 | rr_exp[k]);
            for (int t = 0; t < 8 && IRQ !== 1'b1; t++) begin
                step();
            end
            compare({31'd0, IRQ});
            addr = INTC_CLAIM;
            #1;
            compare(DEVIntc_RD);
            id_v = DEVIntc_RD[2:0];
            we = 1'b1; DEV_WD = {29'd0, id_v};
            step();
            we = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
